// File: rtl/llm_ecc_err_log_if.sv
// ECC error-log interface: event input from the ECC controller, show-ahead log pop,
// counters and the interrupt toward the CSR side.
interface llm_ecc_err_log_if #(
  parameter int unsigned LOG_DEPTH  = 8,
  parameter int unsigned ADDR_WIDTH = 32
);
  localparam int unsigned CntW = $clog2(LOG_DEPTH + 1);

  logic                  evt_valid;
  logic                  evt_src;
  logic [2:0]            evt_status;
  logic [ADDR_WIDTH-1:0] evt_addr;
  logic                  log_valid;
  logic [ADDR_WIDTH+7:0] log_entry;
  logic                  log_pop;
  logic [CntW-1:0]       log_count;
  logic [15:0]           overflow_count;
  logic                  uncorr_flag;
  logic                  irq_en;
  logic                  irq_clr;
  logic                  irq;

  // Driving side: ECC controller events plus CSR/firmware controls.
  modport master (
    output evt_valid, evt_src, evt_status, evt_addr, log_pop, irq_en, irq_clr,
    input  log_valid, log_entry, log_count, overflow_count, uncorr_flag, irq
  );

  // The error log itself.
  modport slave (
    input  evt_valid, evt_src, evt_status, evt_addr, log_pop, irq_en, irq_clr,
    output log_valid, log_entry, log_count, overflow_count, uncorr_flag, irq
  );
endinterface

// File: rtl/llm_ecc_err_log.sv
// ECC error-event log: captures non-zero check results as sequenced entries in a small
// FIFO, counts drops while full and raises a maskable level interrupt.
module llm_ecc_err_log #(
  parameter int unsigned LOG_DEPTH     = 8,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned IRQ_THRESHOLD = 4
) (
  input logic                clk,
  input logic                rst_n,
  llm_ecc_err_log_if.slave   bus_io
);

  localparam int unsigned PtrW   = $clog2(LOG_DEPTH);
  localparam int unsigned CntW   = $clog2(LOG_DEPTH + 1);
  localparam int unsigned EntryW = ADDR_WIDTH + 8;

  typedef enum logic {StIdle, StPend} irq_state_e;

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [15:0]       ovf_cnt_q, ovf_cnt_d;
  logic [3:0]        seq_q, seq_d;
  logic              uncorr_q, uncorr_d;
  logic              ovf_sticky_q, ovf_sticky_d;
  irq_state_e        state_q, state_d;
  logic [EntryW-1:0] mem_q [LOG_DEPTH];

  logic              qual, empty, full, pop_ok, push_ok, drop, cond;
  logic [2:0]        status_log;
  logic [EntryW-1:0] wr_entry;

  // Accept/drop decisions and next-state of pointers, counters and sticky flags.
  always_comb begin
    qual       = bus_io.evt_valid && (bus_io.evt_status != 3'b000);
    empty      = (count_q == '0);
    full       = (count_q == CntW'(LOG_DEPTH));
    pop_ok     = bus_io.log_pop && !empty;
    // A pop in the same cycle frees a slot, so a full log still accepts the push.
    push_ok    = qual && (!full || pop_ok);
    drop       = qual && !push_ok;
    // Reserved 1xx codes are folded into multi-bit.
    status_log = bus_io.evt_status[2] ? 3'b011 : bus_io.evt_status;
    wr_entry   = {seq_q, bus_io.evt_src, status_log, bus_io.evt_addr};

    wr_ptr_d     = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d     = pop_ok  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    seq_d        = qual    ? seq_q + 4'd1        : seq_q;

    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CntW'(1);
    end

    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    // Setting beats an irq_clr arriving in the same cycle.
    uncorr_d = uncorr_q;
    if (push_ok && status_log[1]) begin
      uncorr_d = 1'b1;
    end else if (bus_io.irq_clr) begin
      uncorr_d = 1'b0;
    end

    ovf_sticky_d = ovf_sticky_q;
    if (drop) begin
      ovf_sticky_d = 1'b1;
    end else if (bus_io.irq_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  // Interrupt FSM: condition is taken from registered state only.
  always_comb begin
    cond    = (count_q >= CntW'(IRQ_THRESHOLD)) | uncorr_q | ovf_sticky_q;
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus_io.irq_en && cond) state_d = StPend;
      StPend: if (bus_io.irq_clr || !bus_io.irq_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_cnt_q    <= '0;
      seq_q        <= '0;
      uncorr_q     <= 1'b0;
      ovf_sticky_q <= 1'b0;
      state_q      <= StIdle;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ovf_cnt_q    <= ovf_cnt_d;
      seq_q        <= seq_d;
      uncorr_q     <= uncorr_d;
      ovf_sticky_q <= ovf_sticky_d;
      state_q      <= state_d;
    end
  end

  // Log storage; contents are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LOG_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign bus_io.log_valid      = !empty;
  assign bus_io.log_entry      = empty ? '0 : mem_q[rd_ptr_q];
  assign bus_io.log_count      = count_q;
  assign bus_io.overflow_count = ovf_cnt_q;
  assign bus_io.uncorr_flag    = uncorr_q;
  assign bus_io.irq            = (state_q == StPend);

endmodule

// File: tb/tb_llm_ecc_err_log.sv
// Self-checking bench for llm_ecc_err_log: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_llm_ecc_err_log;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int TH    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  llm_ecc_err_log_if #(.LOG_DEPTH(DEPTH), .ADDR_WIDTH(AW)) bus ();

  llm_ecc_err_log #(
    .LOG_DEPTH    (DEPTH),
    .ADDR_WIDTH   (AW),
    .IRQ_THRESHOLD(TH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_io(bus)
  );

  // Reference model state.
  logic [AW+7:0] m_q[$];
  int            m_seq;
  int            m_ovf;
  bit            m_uncorr, m_ovfs, m_irq;

  task automatic model_clear();
    m_q.delete();
    m_seq = 0; m_ovf = 0;
    m_uncorr = 0; m_ovfs = 0; m_irq = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.evt_valid = 0; bus.evt_src = 0; bus.evt_status = 0; bus.evt_addr = 0;
    bus.log_pop = 0; bus.irq_clr = 0; bus.irq_en = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock of stimulus; the model advances using the values present at the edge.
  task automatic drive_cycle(input bit v, input bit src, input logic [2:0] st,
                             input logic [AW-1:0] addr, input bit pop, input bit clr);
    int         sz;
    bit         qual, pop_ok, push_ok, drop, cond;
    logic [2:0] sl;
    bus.evt_valid = v; bus.evt_src = src; bus.evt_status = st; bus.evt_addr = addr;
    bus.log_pop = pop; bus.irq_clr = clr;
    @(posedge clk);
    sz      = m_q.size();
    qual    = v && (st != 3'b000);
    pop_ok  = pop && (sz > 0);
    push_ok = qual && ((sz < DEPTH) || pop_ok);
    drop    = qual && !push_ok;
    sl      = st[2] ? 3'b011 : st;
    cond    = (sz >= TH) || m_uncorr || m_ovfs;
    if (m_irq) m_irq = !(clr || !bus.irq_en);
    else       m_irq = bus.irq_en && cond;
    if (push_ok && (sl == 3'b010 || sl == 3'b011)) m_uncorr = 1;
    else if (clr) m_uncorr = 0;
    if (drop) m_ovfs = 1;
    else if (clr) m_ovfs = 0;
    if (pop_ok) void'(m_q.pop_front());
    if (push_ok) m_q.push_back({4'(m_seq), src, sl, addr});
    if (qual) m_seq = (m_seq + 1) % 16;
    if (drop && m_ovf < 65535) m_ovf++;
    #1;
    bus.evt_valid = 0; bus.log_pop = 0; bus.irq_clr = 0; bus.evt_status = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.log_valid !== 1'b0 || bus.log_entry !== '0 || bus.irq !== 1'b0) begin
      $display("FAIL reset_out: valid=%b entry=%h irq=%b want 0/0/0",
               bus.log_valid, bus.log_entry, bus.irq);
    end else n_pass++;
    n_checks++;
    if (bus.log_count !== 4'd0 || bus.overflow_count !== 16'd0 || bus.uncorr_flag !== 1'b0) begin
      $display("FAIL reset_cnt: count=%0d ovf=%0d uncorr=%b want 0/0/0",
               bus.log_count, bus.overflow_count, bus.uncorr_flag);
    end else n_pass++;
  endtask

  task automatic test_basic();
    logic [AW+7:0] exp;
    do_reset();
    bus.irq_en = 1;
    drive_cycle(1, 1, 3'b001, 32'h100, 0, 0);
    drive_cycle(1, 0, 3'b010, 32'h200, 0, 0);
    n_checks++;
    if (bus.uncorr_flag !== 1'b1 || bus.irq !== 1'b0) begin
      $display("FAIL basic_uncorr: uncorr=%b irq=%b want 1/0", bus.uncorr_flag, bus.irq);
    end else n_pass++;
    drive_cycle(1, 0, 3'b000, 32'h300, 0, 0);
    n_checks++;
    if (bus.irq !== 1'b1 || bus.log_count !== 4'd2) begin
      $display("FAIL basic_irq: irq=%b count=%0d want 1/2", bus.irq, bus.log_count);
    end else n_pass++;
    exp = {4'd0, 1'b1, 3'b001, 32'h100};
    n_checks++;
    if (bus.log_entry !== exp) $display("FAIL basic_head: got %h want %h", bus.log_entry, exp);
    else n_pass++;
    drive_cycle(0, 0, 3'b000, 0, 1, 0);
    exp = {4'd1, 1'b0, 3'b010, 32'h200};
    n_checks++;
    if (bus.log_entry !== exp) $display("FAIL basic_second: got %h want %h", bus.log_entry, exp);
    else n_pass++;
    drive_cycle(0, 0, 3'b000, 0, 1, 0);
    n_checks++;
    if (bus.log_valid !== 1'b0 || bus.log_entry !== '0) begin
      $display("FAIL basic_empty: valid=%b entry=%h want 0/0", bus.log_valid, bus.log_entry);
    end else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) drive_cycle(1, 0, 3'b001, AW'(i), 0, 0);
    n_checks++;
    if (bus.log_count !== 4'd8 || bus.overflow_count !== 16'd2) begin
      $display("FAIL ovf_full: count=%0d ovf=%0d want 8/2", bus.log_count, bus.overflow_count);
    end else n_pass++;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bus.log_entry[AW+7:AW+4] !== 4'(i) || bus.log_entry[AW-1:0] !== AW'(i)) begin
        $display("FAIL ovf_seq: got %h want seq %0d addr %0d", bus.log_entry, i, i);
      end else n_pass++;
      drive_cycle(0, 0, 3'b000, 0, 1, 0);
    end
    drive_cycle(1, 0, 3'b001, 32'h55, 0, 0);
    n_checks++;
    if (bus.log_entry[AW+7:AW+4] !== 4'd10) begin
      $display("FAIL ovf_gap: seq=%0d want 10", bus.log_entry[AW+7:AW+4]);
    end else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [AW+7:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) drive_cycle(1, 0, 3'b001, AW'(i), 0, 0);
    drive_cycle(1, 1, 3'b010, 32'hAB, 1, 0);
    n_checks++;
    if (bus.log_count !== 4'd8 || bus.overflow_count !== 16'd0) begin
      $display("FAIL fpp_count: count=%0d ovf=%0d want 8/0", bus.log_count, bus.overflow_count);
    end else n_pass++;
    repeat (7) drive_cycle(0, 0, 3'b000, 0, 1, 0);
    exp = {4'd8, 1'b1, 3'b010, 32'hAB};
    n_checks++;
    if (bus.log_entry !== exp || bus.log_count !== 4'd1) begin
      $display("FAIL fpp_last: got %h count=%0d want %h count=1",
               bus.log_entry, bus.log_count, exp);
    end else n_pass++;
  endtask

  task automatic test_irq_threshold();
    do_reset();
    bus.irq_en = 1;
    repeat (4) drive_cycle(1, 0, 3'b001, 32'h10, 0, 0);
    drive_cycle(0, 0, 3'b000, 0, 0, 0);
    n_checks++;
    if (bus.irq !== 1'b1) $display("FAIL irq_thresh: irq=%b want 1", bus.irq); else n_pass++;
    drive_cycle(0, 0, 3'b000, 0, 0, 1);
    n_checks++;
    if (bus.irq !== 1'b0) $display("FAIL irq_clr_low: irq=%b want 0", bus.irq); else n_pass++;
    drive_cycle(0, 0, 3'b000, 0, 0, 0);
    n_checks++;
    if (bus.irq !== 1'b1) $display("FAIL irq_reassert: irq=%b want 1", bus.irq); else n_pass++;
    drive_cycle(0, 0, 3'b000, 0, 1, 0);
    drive_cycle(0, 0, 3'b000, 0, 0, 1);
    drive_cycle(0, 0, 3'b000, 0, 0, 0);
    drive_cycle(0, 0, 3'b000, 0, 0, 0);
    n_checks++;
    if (bus.irq !== 1'b0 || bus.log_count !== 4'd3) begin
      $display("FAIL irq_below: irq=%b count=%0d want 0/3", bus.irq, bus.log_count);
    end else n_pass++;
  endtask

  task automatic test_clr_collision();
    logic [AW+7:0] exp;
    do_reset();
    bus.irq_en = 1;
    drive_cycle(1, 0, 3'b011, 32'h40, 0, 1);
    n_checks++;
    if (bus.uncorr_flag !== 1'b1) $display("FAIL coll_uncorr: uncorr=%b want 1", bus.uncorr_flag);
    else n_pass++;
    drive_cycle(1, 1, 3'b110, 32'h44, 0, 0);
    n_checks++;
    if (bus.irq !== 1'b1) $display("FAIL coll_irq: irq=%b want 1", bus.irq); else n_pass++;
    bus.irq_en = 0;
    drive_cycle(0, 0, 3'b000, 0, 1, 0);
    n_checks++;
    if (bus.irq !== 1'b0) $display("FAIL coll_irq_dis: irq=%b want 0", bus.irq); else n_pass++;
    exp = {4'd1, 1'b1, 3'b011, 32'h44};
    n_checks++;
    if (bus.log_entry !== exp) $display("FAIL coll_reserved: got %h want %h", bus.log_entry, exp);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [AW+7:0] exp;
    do_reset();
    bus.irq_en = 1;
    drive_cycle(1, 0, 3'b010, 32'h1, 0, 0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 3'b001, AW'(i + 2), 0, 0);
    drive_cycle(0, 0, 3'b000, 0, 0, 0);
    n_checks++;
    if (bus.irq !== 1'b1 || bus.log_count !== 4'd5) begin
      $display("FAIL arst_pre: irq=%b count=%0d want 1/5", bus.irq, bus.log_count);
    end else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.log_valid !== 1'b0 || bus.log_entry !== '0 || bus.log_count !== 4'd0 ||
        bus.uncorr_flag !== 1'b0 || bus.irq !== 1'b0) begin
      $display("FAIL arst_clear: valid=%b entry=%h count=%0d uncorr=%b irq=%b want all 0",
               bus.log_valid, bus.log_entry, bus.log_count, bus.uncorr_flag, bus.irq);
    end else n_pass++;
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_cycle(1, 0, 3'b001, 32'h77, 0, 0);
    exp = {4'd0, 1'b0, 3'b001, 32'h77};
    n_checks++;
    if (bus.log_entry !== exp) $display("FAIL arst_seq: got %h want %h", bus.log_entry, exp);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AW+7:0] exp;
    bit            busy;
    do_reset();
    bus.irq_en = 1;
    for (int i = 0; i < 600; i++) begin
      busy = ((i / 60) % 2) == 0;
      if ($urandom_range(31) == 0) bus.irq_en = ~bus.irq_en;
      drive_cycle($urandom_range(3) != 0, 1'($urandom), 3'($urandom), $urandom,
                  busy ? ($urandom_range(4) == 0) : ($urandom_range(2) != 0),
                  $urandom_range(7) == 0);
      exp = (m_q.size() > 0) ? m_q[0] : '0;
      n_checks++;
      if (bus.log_entry !== exp || bus.log_valid !== (m_q.size() > 0)) begin
        $display("FAIL rnd_entry@%0d: got %h valid=%b want %h valid=%b",
                 i, bus.log_entry, bus.log_valid, exp, m_q.size() > 0);
      end else n_pass++;
      n_checks++;
      if (bus.log_count !== 4'(m_q.size()) || bus.overflow_count !== 16'(m_ovf)) begin
        $display("FAIL rnd_count@%0d: count=%0d ovf=%0d want %0d/%0d",
                 i, bus.log_count, bus.overflow_count, m_q.size(), m_ovf);
      end else n_pass++;
      n_checks++;
      if (bus.uncorr_flag !== m_uncorr || bus.irq !== m_irq) begin
        $display("FAIL rnd_flags@%0d: uncorr=%b irq=%b want %b/%b",
                 i, bus.uncorr_flag, bus.irq, m_uncorr, m_irq);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_irq_threshold();
    test_clr_collision();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
